// File: rtl/sm4_blk_ctrl.sv
// rtl/sm4_blk_ctrl.sv - SM4 block sequencer between input buffer, round engine and output stage
// Optional feature macro: SM4_BLK_CNT_EN (processed data block counter on blk_cnt_o)
module sm4_blk_ctrl #(
   parameter int BLOCK_LENGTH  = 128,
   parameter int ROUND_NUM     = 32,
   parameter int TIMEOUT_SLACK = 8,
   parameter int TCNT_WIDTH    = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg,
   input  logic                    blk_valid_i,
   input  logic [BLOCK_LENGTH:0]   blk_i,
   input  logic                    in_err_i,
   output logic                    stall,
   output logic                    keep_data,
   output logic                    key_start_o,
   input  logic                    key_done_i,
   output logic                    core_start_o,
   output logic [BLOCK_LENGTH-1:0] core_din_o,
   input  logic                    core_done_i,
   input  logic [BLOCK_LENGTH-1:0] core_dout_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [BLOCK_LENGTH-1:0] out_data_o,
   output logic                    out_eop_o,
   output logic                    key_ready_o,
   output logic                    err_o,
   output logic [31:0]             blk_cnt_o
);

   // Last watchdog value at which a done pulse is still accepted
   localparam logic [TCNT_WIDTH-1:0] TLIMIT = TCNT_WIDTH'(ROUND_NUM + TIMEOUT_SLACK);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY_EXP,
      S_RUN,
      S_OUT,
      S_ERR
   } state_t;

   state_t                state;
   logic [TCNT_WIDTH-1:0] tcnt;
   logic                  eop_q;
   logic                  err_req;

   // Any condition that forces ERR; framing error outranks everything else
   always_comb begin
      err_req = 1'b0;
      if (state != S_ERR) begin
         if (in_err_i)
            err_req = 1'b1;
         else if (blk_valid_i && (state != S_IDLE))
            err_req = 1'b1;
         else if (blk_valid_i && !cfg && !key_ready_o)
            err_req = 1'b1;
         else if ((state == S_KEY_EXP) && !key_done_i && (tcnt == TLIMIT))
            err_req = 1'b1;
         else if ((state == S_RUN) && !core_done_i && (tcnt == TLIMIT))
            err_req = 1'b1;
      end
   end

   // Sequencer FSM with registered outputs and engine watchdog
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         tcnt         <= '0;
         eop_q        <= 1'b0;
         stall        <= 1'b0;
         keep_data    <= 1'b0;
         key_start_o  <= 1'b0;
         core_start_o <= 1'b0;
         core_din_o   <= '0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
         out_eop_o    <= 1'b0;
         key_ready_o  <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         key_start_o  <= 1'b0;
         core_start_o <= 1'b0;
         if (err_req) begin
            state       <= S_ERR;
            err_o       <= 1'b1;
            keep_data   <= 1'b1;
            stall       <= 1'b1;
            key_ready_o <= 1'b0;
            out_valid_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (blk_valid_i) begin
                     // err_req already rejected data blocks without a key
                     core_din_o <= blk_i[BLOCK_LENGTH:1];
                     tcnt       <= '0;
                     stall      <= 1'b1;
                     if (cfg) begin
                        key_start_o <= 1'b1;
                        key_ready_o <= 1'b0;
                        state       <= S_KEY_EXP;
                     end else begin
                        eop_q        <= blk_i[0];
                        core_start_o <= 1'b1;
                        state        <= S_RUN;
                     end
                  end
               end
               S_KEY_EXP: begin
                  if (key_done_i) begin
                     key_ready_o <= 1'b1;
                     stall       <= 1'b0;
                     state       <= S_IDLE;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               S_RUN: begin
                  if (core_done_i) begin
                     out_data_o  <= core_dout_i;
                     out_eop_o   <= eop_q;
                     out_valid_o <= 1'b1;
                     state       <= S_OUT;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               S_OUT: begin
                  if (out_ready_i) begin
                     out_valid_o <= 1'b0;
                     stall       <= 1'b0;
                     state       <= S_IDLE;
                  end
               end
               S_ERR: begin
                  if (cfg && !in_err_i) begin
                     err_o     <= 1'b0;
                     keep_data <= 1'b0;
                     stall     <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SM4_BLK_CNT_EN
   logic [31:0] blk_cnt_q;

   // Count completed output transfers; survives ERR, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blk_cnt_q <= 32'd0;
      else if ((state == S_OUT) && out_ready_i && !err_req)
         blk_cnt_q <= blk_cnt_q + 32'd1;
   end

   assign blk_cnt_o = blk_cnt_q;
`else
   assign blk_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sm4_blk_ctrl.sv
// tb/tb_sm4_blk_ctrl.sv - self-checking bench for sm4_blk_ctrl
module tb_sm4_blk_ctrl;

   localparam int BL    = 128;
   localparam int LIMIT = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg = 1'b0;
   logic          blk_valid_i = 1'b0;
   logic [BL:0]   blk_i = '0;
   logic          in_err_i = 1'b0;
   logic          stall;
   logic          keep_data;
   logic          key_start_o;
   logic          key_done_i = 1'b0;
   logic          core_start_o;
   logic [BL-1:0] core_din_o;
   logic          core_done_i = 1'b0;
   logic [BL-1:0] core_dout_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [BL-1:0] out_data_o;
   logic          out_eop_o;
   logic          key_ready_o;
   logic          err_o;
   logic [31:0]   blk_cnt_o;

   int            n_cmp = 0;
   int            n_err = 0;
   int            exp_cnt = 0;

   sm4_blk_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .cfg          (cfg),
      .blk_valid_i  (blk_valid_i),
      .blk_i        (blk_i),
      .in_err_i     (in_err_i),
      .stall        (stall),
      .keep_data    (keep_data),
      .key_start_o  (key_start_o),
      .key_done_i   (key_done_i),
      .core_start_o (core_start_o),
      .core_din_o   (core_din_o),
      .core_done_i  (core_done_i),
      .core_dout_i  (core_dout_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_eop_o    (out_eop_o),
      .key_ready_o  (key_ready_o),
      .err_o        (err_o),
      .blk_cnt_o    (blk_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BL-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] exp_blk();
`ifdef SM4_BLK_CNT_EN
      return 32'(exp_cnt);
`else
      return 32'd0;
`endif
   endfunction

   task automatic load_key(input logic [BL-1:0] k, input int lat);
      cfg = 1'b1; blk_i = {k, 1'b0}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (lat) tick();
      key_done_i = 1'b1;
      tick();
      key_done_i = 1'b0; cfg = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if ({stall, keep_data, key_start_o, core_start_o, out_valid_o, out_eop_o, key_ready_o, err_o} !== 8'h00) begin n_err++; $display("FAIL reset_flags got=%b want=00000000", {stall, keep_data, key_start_o, core_start_o, out_valid_o, out_eop_o, key_ready_o, err_o}); end
      n_cmp++; if ({core_din_o, out_data_o, blk_cnt_o} !== '0) begin n_err++; $display("FAIL reset_data din=%h out=%h cnt=%h want=0", core_din_o, out_data_o, blk_cnt_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_key_load();
      logic [BL-1:0] k;
      int starts;
      k = rnd128();
      cfg = 1'b1; blk_i = {k, 1'b0}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0; blk_i = {rnd128(), 1'b1};
      starts = key_start_o ? 1 : 0;
      n_cmp++; if ({core_din_o, stall, key_ready_o} !== {k, 1'b1, 1'b0}) begin n_err++; $display("FAIL key_launch din=%h stall=%b kr=%b want din=%h stall=1 kr=0", core_din_o, stall, key_ready_o, k); end
      repeat (32) begin
         tick();
         if (key_start_o) starts++;
      end
      key_done_i = 1'b1;
      tick();
      key_done_i = 1'b0; cfg = 1'b0;
      n_cmp++; if (starts !== 1) begin n_err++; $display("FAIL key_start_pulses got=%0d want=1", starts); end
      n_cmp++; if ({key_ready_o, stall, err_o, out_valid_o} !== 4'b1000) begin n_err++; $display("FAIL key_done kr/stall/err/ov got=%b want=1000", {key_ready_o, stall, err_o, out_valid_o}); end
   endtask

   task automatic test_encrypt();
      logic [BL-1:0] p, c;
      int extra;
      p = 128'h0123456789abcdeffedcba9876543210;
      c = 128'h681edf34d206965e86b3e94f536e4246;
      extra = 0;
      cfg = 1'b0; blk_i = {p, 1'b1}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0; blk_i = {rnd128(), 1'b0};
      n_cmp++; if ({core_start_o, core_din_o} !== {1'b1, p}) begin n_err++; $display("FAIL enc_start cs=%b din=%h want cs=1 din=%h", core_start_o, core_din_o, p); end
      repeat (31) begin
         tick();
         if (core_start_o) extra++;
      end
      n_cmp++; if ({extra, core_din_o} !== {32'd0, p}) begin n_err++; $display("FAIL enc_hold extra_starts=%0d din=%h want 0 / %h", extra, core_din_o, p); end
      core_dout_i = c; core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0; core_dout_i = rnd128();
      n_cmp++; if ({out_valid_o, out_data_o, out_eop_o} !== {1'b1, c, 1'b1}) begin n_err++; $display("FAIL enc_result ov=%b data=%h eop=%b want 1 %h 1", out_valid_o, out_data_o, out_eop_o, c); end
      tick();
      n_cmp++; if ({out_valid_o, out_data_o, out_eop_o} !== {1'b1, c, 1'b1}) begin n_err++; $display("FAIL enc_result_hold ov=%b data=%h eop=%b want 1 %h 1", out_valid_o, out_data_o, out_eop_o, c); end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0; exp_cnt++;
      n_cmp++; if ({out_valid_o, stall, blk_cnt_o} !== {1'b0, 1'b0, exp_blk()}) begin n_err++; $display("FAIL enc_xfer ov=%b stall=%b cnt=%0d want 0 0 %0d", out_valid_o, stall, blk_cnt_o, exp_blk()); end
   endtask

   task automatic test_back_pressure();
      logic [BL-1:0] p, c;
      int unstable, xfers;
      p = rnd128(); c = rnd128();
      unstable = 0; xfers = 0;
      blk_i = {p, 1'b0}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (5) tick();
      core_dout_i = c; core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0; core_dout_i = rnd128();
      for (int i = 0; i < 10; i++) begin
         if (out_valid_o && out_ready_i) xfers++;
         tick();
         if ({out_valid_o, out_data_o, out_eop_o, stall} !== {1'b1, c, 1'b0, 1'b1}) unstable++;
      end
      n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL bp_stable unstable_cycles=%0d want=0", unstable); end
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (out_valid_o && out_ready_i) xfers++;
         tick();
      end
      out_ready_i = 1'b0; exp_cnt++;
      n_cmp++; if (xfers !== 1) begin n_err++; $display("FAIL bp_xfers got=%0d want=1", xfers); end
      n_cmp++; if (blk_cnt_o !== exp_blk()) begin n_err++; $display("FAIL bp_cnt got=%0d want=%0d", blk_cnt_o, exp_blk()); end
   endtask

   task automatic test_no_key();
      int starts;
      starts = 0;
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      exp_cnt = 0;
      tick();
      cfg = 1'b0; blk_i = {rnd128(), 1'b1}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      if (core_start_o) starts++;
      n_cmp++; if ({err_o, keep_data, stall, key_ready_o} !== 4'b1110) begin n_err++; $display("FAIL nokey_err err/kd/stall/kr got=%b want=1110", {err_o, keep_data, stall, key_ready_o}); end
      repeat (3) begin
         tick();
         if (core_start_o) starts++;
      end
      n_cmp++; if (starts !== 0) begin n_err++; $display("FAIL nokey_start pulses=%0d want=0", starts); end
      cfg = 1'b1;
      tick();
      cfg = 1'b0;
      n_cmp++; if ({err_o, keep_data, stall} !== 3'b000) begin n_err++; $display("FAIL nokey_clear err/kd/stall got=%b want=000", {err_o, keep_data, stall}); end
   endtask

   task automatic test_timeout();
      load_key(rnd128(), 3);
      blk_i = {rnd128(), 1'b1}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (LIMIT) tick();
      n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL tmo_early err=%b want=0", err_o); end
      tick();
      n_cmp++; if ({err_o, key_ready_o, out_valid_o} !== 3'b100) begin n_err++; $display("FAIL tmo_err err/kr/ov got=%b want=100", {err_o, key_ready_o, out_valid_o}); end
      core_dout_i = rnd128(); core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      n_cmp++; if ({err_o, out_valid_o} !== 2'b10) begin n_err++; $display("FAIL tmo_done_ignored err/ov got=%b want=10", {err_o, out_valid_o}); end
      cfg = 1'b1;
      tick();
      cfg = 1'b0;
      load_key(rnd128(), LIMIT);
      n_cmp++; if ({key_ready_o, err_o} !== 2'b10) begin n_err++; $display("FAIL tmo_key_at_limit kr/err got=%b want=10", {key_ready_o, err_o}); end
      blk_i = {rnd128(), 1'b0}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (LIMIT) tick();
      core_dout_i = rnd128(); core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      n_cmp++; if ({out_valid_o, out_data_o, err_o} !== {1'b1, core_dout_i, 1'b0}) begin n_err++; $display("FAIL tmo_at_limit ov=%b data=%h err=%b want 1 %h 0", out_valid_o, out_data_o, err_o, core_dout_i); end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0; exp_cnt++;
   endtask

   task automatic test_in_err();
      blk_i = {rnd128(), 1'b0}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (3) tick();
      in_err_i = 1'b1; core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      n_cmp++; if ({err_o, key_ready_o, out_valid_o} !== 3'b100) begin n_err++; $display("FAIL inerr_run err/kr/ov got=%b want=100", {err_o, key_ready_o, out_valid_o}); end
      cfg = 1'b1;
      tick();
      n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL inerr_hold err=%b want=1", err_o); end
      in_err_i = 1'b0;
      tick();
      cfg = 1'b0;
      n_cmp++; if ({err_o, stall} !== 2'b00) begin n_err++; $display("FAIL inerr_clear err/stall got=%b want=00", {err_o, stall}); end
      load_key(rnd128(), 2);
      blk_i = {rnd128(), 1'b0}; blk_valid_i = 1'b1;
      tick();
      tick();
      blk_valid_i = 1'b0;
      n_cmp++; if ({err_o, key_ready_o} !== 2'b10) begin n_err++; $display("FAIL blk_outside_idle err/kr got=%b want=10", {err_o, key_ready_o}); end
      cfg = 1'b1;
      tick();
      cfg = 1'b0;
   endtask

   task automatic test_random();
      logic [BL-1:0] p, c, k;
      logic e;
      int lat, rdly;
      k = rnd128();
      load_key(k, $urandom_range(0, LIMIT));
      for (int i = 0; i < 24; i++) begin
         p = rnd128(); c = rnd128(); e = 1'($urandom_range(0, 1));
         lat = $urandom_range(0, LIMIT + 4); rdly = $urandom_range(0, 4);
         cfg = 1'b0; blk_i = {p, e}; blk_valid_i = 1'b1;
         tick();
         blk_valid_i = 1'b0; blk_i = {rnd128(), ~e};
         n_cmp++; if ({core_start_o, core_din_o} !== {1'b1, p}) begin n_err++; $display("FAIL rnd_start[%0d] cs=%b din=%h want 1 %h", i, core_start_o, core_din_o, p); end
         if (lat <= LIMIT) begin
            repeat (lat) tick();
            core_dout_i = c; core_done_i = 1'b1;
            tick();
            core_done_i = 1'b0; core_dout_i = rnd128();
            repeat (rdly) tick();
            n_cmp++; if ({out_valid_o, out_data_o, out_eop_o} !== {1'b1, c, e}) begin n_err++; $display("FAIL rnd_out[%0d] ov=%b data=%h eop=%b want 1 %h %b", i, out_valid_o, out_data_o, out_eop_o, c, e); end
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0; exp_cnt++;
            n_cmp++; if ({out_valid_o, stall, blk_cnt_o} !== {1'b0, 1'b0, exp_blk()}) begin n_err++; $display("FAIL rnd_xfer[%0d] ov=%b stall=%b cnt=%0d want 0 0 %0d", i, out_valid_o, stall, blk_cnt_o, exp_blk()); end
         end else begin
            repeat (LIMIT + 1) tick();
            n_cmp++; if ({err_o, key_ready_o, out_valid_o} !== 3'b100) begin n_err++; $display("FAIL rnd_tmo[%0d] err/kr/ov got=%b want=100", i, {err_o, key_ready_o, out_valid_o}); end
            cfg = 1'b1;
            tick();
            cfg = 1'b0;
            load_key(rnd128(), $urandom_range(0, LIMIT));
            n_cmp++; if ({err_o, key_ready_o, blk_cnt_o} !== {2'b01, exp_blk()}) begin n_err++; $display("FAIL rnd_recover[%0d] err=%b kr=%b cnt=%0d want 0 1 %0d", i, err_o, key_ready_o, blk_cnt_o, exp_blk()); end
         end
      end
   endtask

   task automatic test_async_reset();
      blk_i = {rnd128(), 1'b1}; blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      repeat (4) tick();
      core_dout_i = rnd128(); core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL arst_pre ov=%b want=1", out_valid_o); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({stall, keep_data, key_start_o, core_start_o, out_valid_o, out_eop_o, key_ready_o, err_o} !== 8'h00) begin n_err++; $display("FAIL arst_flags got=%b want=00000000", {stall, keep_data, key_start_o, core_start_o, out_valid_o, out_eop_o, key_ready_o, err_o}); end
      n_cmp++; if ({core_din_o, out_data_o, blk_cnt_o} !== '0) begin n_err++; $display("FAIL arst_data din=%h out=%h cnt=%h want=0", core_din_o, out_data_o, blk_cnt_o); end
      #2 rst = 1'b0;
      exp_cnt = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_key_load();
      test_encrypt();
      test_back_pressure();
      test_no_key();
      test_timeout();
      test_in_err();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sm4_blk_ctrl.md
Name: sm4_blk_ctrl

Overview:
Block-level sequencer between the serial-to-parallel input buffer and the SM4 round engine.
- Accepts 128-bit blocks (plus an eop flag) from the input buffer and classifies each as a key or a data block by `cfg`.
- Launches key expansion or encryption and waits for the engine.
- Presents each result to the parallel-to-serial stage with a valid/ready handshake.
- Back-pressures the input buffer via `stall`/`keep_data`, watches for engine timeout and input framing errors, and holds a sticky error until reconfiguration.

Parameters:
BLOCK_LENGTH, 128, block width in bits
ROUND_NUM, 32, nominal engine latency in cycles (rounds)
TIMEOUT_SLACK, 8, extra cycles allowed beyond ROUND_NUM before timeout
TCNT_WIDTH, 6, watchdog counter width; must hold ROUND_NUM+TIMEOUT_SLACK

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
cfg  input  1  1 = incoming blocks are key material / clear error; 0 = data blocks
blk_valid_i  input  1  one-cycle pulse from input buffer: blk_i is complete
blk_i  input  BLOCK_LENGTH+1  {block[127:0], eop}
in_err_i  input  1  framing error from input buffer (sticky upstream)
stall  output  1  freezes input buffer counter and data register
keep_data  output  1  freezes input buffer data register only
key_start_o  output  1  one-cycle pulse: begin key expansion on core_din_o
key_done_i  input  1  one-cycle pulse: key expansion complete
core_start_o  output  1  one-cycle pulse: begin encryption of core_din_o
core_din_o  output  BLOCK_LENGTH  latched block to engine
core_done_i  input  1  one-cycle pulse: core_dout_i valid
core_dout_i  input  BLOCK_LENGTH  engine result
out_valid_o  output  1  result available
out_ready_i  input  1  downstream accepts result
out_data_o  output  BLOCK_LENGTH  result block
out_eop_o  output  1  eop of the source block
key_ready_o  output  1  a valid expanded key is loaded
err_o  output  1  sticky error
blk_cnt_o  output  32  processed data block count (optional feature)

Behaviour:
- Reset (`rst`=1, async): state = IDLE. All outputs are 0; internal block/eop latches are 0.
- States: IDLE, KEY_EXP, RUN, OUT, ERR.
- IDLE:
  - `blk_valid_i` && `cfg`=1 → latch `blk_i`, pulse `key_start_o` next cycle, clear `key_ready_o`, go to KEY_EXP.
  - `blk_valid_i` && `cfg`=0 && `key_ready_o` → latch block and eop, pulse `core_start_o` next cycle, go to RUN.
  - `blk_valid_i` && `cfg`=0 && !`key_ready_o` → go to ERR.
- KEY_EXP: `key_done_i` → set `key_ready_o`, go to IDLE.
- RUN: `core_done_i` → latch `core_dout_i` into `out_data_o`, go to OUT.
- OUT:
  - `out_valid_o`=1, with data and eop stable until `out_ready_i`.
  - On the handshake cycle, go to IDLE; `out_valid_o` drops the next cycle.
- Watchdog in KEY_EXP/RUN:
  - Counter starts at 0 on entry and increments each cycle.
  - Reaching ROUND_NUM+TIMEOUT_SLACK without done → ERR.
  - Done arriving on the same cycle as the limit counts as success.
- `in_err_i`=1 in any non-ERR state → ERR next cycle; this has priority over all other transitions.
- ERR:
  - `err_o`=1 and `keep_data`=1; `key_ready_o` is cleared.
  - Engine done pulses are ignored.
  - Exit to IDLE only when `cfg`=1 and `in_err_i`=0; `err_o` clears on the same edge.
- `stall` = 1 in KEY_EXP, RUN, OUT and ERR.
  - The input buffer may present at most one block in the cycle `stall` rises; that block is dropped and flagged: `blk_valid_i` outside IDLE → ERR.
- `core_din_o` holds the latched block from the start pulse until the next capture.
- Stray `key_done_i`/`core_done_i` in IDLE or OUT: ignored.
- Latency: `blk_valid_i` to `core_start_o` = 1 cycle; `core_done_i` to `out_valid_o` = 1 cycle.

Optional Feature:
SM4_BLK_CNT_EN
- Defined: `blk_cnt_o` increments by 1 on each OUT handshake and wraps from 2^32-1 to 0. It is cleared by `rst`; it is not cleared by ERR.
- Undefined: `blk_cnt_o` is tied to 0 and no counter flops are present.

Test Plan:
- Key load: `cfg`=1, `blk_valid_i` with key K, `key_done_i` 32 cycles after `key_start_o` → `key_start_o` pulses exactly once, `key_ready_o`=1, state IDLE, `err_o`=0.
- Encrypt: after key load, `cfg`=0, block 0x0123456789abcdeffedcba9876543210 with eop=1, engine returns 0x681edf34d206965e86b3e94f536e4246 → `out_valid_o`=1 holding that value with `out_eop_o`=1 until `out_ready_i`; `blk_cnt_o`=1 with the macro defined.
- Back-pressure: `out_ready_i`=0 for 10 cycles → `out_valid_o`, `out_data_o` and `stall` stable for all 10 cycles; exactly one transfer on release.
- Data without key: after reset, `cfg`=0 and `blk_valid_i` → `err_o`=1 the next cycle, no `core_start_o`; `cfg`=1 clears `err_o`, state returns to IDLE.
- Timeout: no `core_done_i` for 40 cycles (ROUND_NUM=32, TIMEOUT_SLACK=8) → ERR at cycle 40; with done at exactly cycle 40 → OUT instead.
- Mid-run error and reset: assert `in_err_i` during RUN → ERR and `key_ready_o`=0. Assert `rst` during OUT → all outputs 0 immediately, without waiting for a clock edge.
